sbox_f_sequencer: RTL and testbench
===================================

// Module: sbox_f_sequencer
// PURPOSE
//   Sequences the Blowfish F-function over ONE shared S-box lookup port (s1..s4 muxed externally).
//   Splits 32-bit half-block x into bytes a,b,c,d (a = x[31:24]) and issues four lookups in order.
//   Computes F = ((S1[a] + S2[b]) ^ S3[c]) + S4[d], all mod 2^32.
//   Sits between the round controller (start/done) and the S-box ROM mux (sel/idx/data).
// PARAMETERS
//   DATA_W  32  S-box word / F result width
//   IDX_W   8   S-box index width (byte lane of x)
// PORTS
//   clk        in   1       system clock, all logic on rising edge
//   rst        in   1       synchronous, active-high reset
//   start      in   1       request F(x_in); accepted only in IDLE or DONE
//   x_in       in   32      half-block input, sampled on accepted start
//   busy       out  1       high while a computation is in progress
//   done       out  1       one-cycle pulse: f_out valid
//   f_out      out  DATA_W  F result, held until next accepted start
//   sbox_sel   out  2       S-box select: 0=S1, 1=S2, 2=S3, 3=S4
//   sbox_idx   out  IDX_W   S-box index for current lookup
//   sbox_data  in   DATA_W  S-box word for (sbox_sel, sbox_idx)
// BEHAVIOUR
//   - Reset: state=IDLE; busy=0, done=0, f_out=0, sbox_sel=0, sbox_idx=0, acc=0, x_reg=0.
//   - FSM: IDLE -> LK0 -> LK1 -> LK2 -> LK3 -> DONE -> (IDLE | LK0).
//   - IDLE: start=1 latches x_reg=x_in, next LK0; start=0 stays.
//   - LKn (n=0..3): sbox_sel=n, sbox_idx = x_reg byte n (LK0 = [31:24] ... LK3 = [7:0]).
//   - sbox_data sampled at end of each LKn cycle.
//   - Accumulate: LK0 acc=data; LK1 acc=acc+data; LK2 acc=acc^data; LK3 f_out=acc+data.
//   - Adds wrap mod 2^DATA_W; carry discarded; no overflow flag.
//   - DONE: done=1 for exactly one cycle, busy=0.
//   - DONE + start=1: new x latched, goes straight to LK0 (back-to-back, no idle gap).
//   - DONE + start=0: goes to IDLE.
//   - Latency: start accepted in cycle 0; lookups in cycles 1-4; done=1 in cycle 5.
//   - busy=1 exactly in cycles 1-4 (LKn states).
//   - start while busy: ignored, not queued; x_in changes while busy have no effect.
//   - sbox_sel/sbox_idx registered; in IDLE/DONE they hold their last values (no glitching).
//   - f_out changes only at end of LK3; holds through IDLE.
//   - rst asserted mid-operation: abort, next cycle IDLE, all outputs at reset values, no done.
//   - rst and start in the same cycle: rst wins, start dropped.
// CONFIGURATION
//   SBOX_SYNC_ROM_EN
//   - Undefined: sbox_data is combinational w.r.t. sel/idx; each LKn lasts 1 cycle, done in cycle 5.
//   - Defined: sbox_data arrives one cycle after sel/idx (registered ROM).
//     - Each LKn lasts 2 cycles: address phase, then capture phase.
//     - sel/idx held for both cycles; data sampled at end of the 2nd cycle.
//     - busy in cycles 1-8; done=1 in cycle 9.
//     - All other rules unchanged.
// TESTING
//   Bench S-box model: data = idx << (8*sel) unless stated. Check done timing in both macro builds.
//   1. Reset -> busy=0, done=0, f_out=0, sbox_sel=0, sbox_idx=0.
//   2. start, x=32'h01020304 -> sel/idx seq 0/01,1/02,2/03,3/04; done in cycle 5; f_out=32'h04030201.
//   3. Model returns 32'hFFFFFFFF always, any x -> f_out=32'h00000000 (add wrap, xor, add wrap).
//   4. Back-to-back: start again in DONE cycle with x=32'h0A0B0C0D -> no idle gap; f_out=32'h0D0C0B0A.
//   5. start pulsed in cycles 2 and 3 with other x values -> ignored; result = first x only; one done.
//   6. rst in cycle 3 of a run -> IDLE next cycle, f_out=0, no done; new start completes normally.

Source files
------------

// File: rtl/sbox_f_sequencer.sv
// sbox_f_sequencer: Blowfish F-function sequenced over one shared S-box lookup port
// F = ((S1[a] + S2[b]) ^ S3[c]) + S4[d], with x = {a,b,c,d}, all adds mod 2^DATA_W.
// Ports: clk, rst (sync, active-high), start/x_in (request), busy/done/f_out (result),
//        sbox_sel/sbox_idx (lookup address), sbox_data (lookup word).
// Macro SBOX_SYNC_ROM_EN: sbox_data arrives one cycle after sel/idx, so each lookup
// takes an address cycle plus a capture cycle.
module sbox_f_sequencer #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       x_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] f_out,
  output logic [1:0]        sbox_sel,
  output logic [IDX_W-1:0]  sbox_idx,
  input  logic [DATA_W-1:0] sbox_data
);
  typedef enum logic [2:0] {IDLE, LK0, LK1, LK2, LK3, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] acc;
  // Remaining bytes, left-aligned; the top byte is the next lookup index.
  logic [31:0] x_reg;
  logic cap;
`ifdef SBOX_SYNC_ROM_EN
  logic ph;
  assign cap = ph;
`else
  assign cap = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      f_out    <= '0;
      sbox_sel <= '0;
      sbox_idx <= '0;
      acc      <= '0;
      x_reg    <= '0;
`ifdef SBOX_SYNC_ROM_EN
      ph       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
`ifdef SBOX_SYNC_ROM_EN
          ph <= 1'b0;
`endif
          if (start) begin
            state    <= LK0;
            busy     <= 1'b1;
            sbox_sel <= 2'd0;
            sbox_idx <= x_in[31 -: IDX_W];
            x_reg    <= x_in << IDX_W;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
`ifdef SBOX_SYNC_ROM_EN
          ph <= ~ph;
`endif
          if (cap) begin
            acc <= state == LK0 ? sbox_data : state == LK1 ? acc + sbox_data : acc ^ sbox_data;
            if (state == LK3) begin
              f_out <= acc + sbox_data;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state    <= state_t'(state + 3'd1);
              sbox_sel <= sbox_sel + 2'd1;
              sbox_idx <= x_reg[31 -: IDX_W];
              x_reg    <= x_reg << IDX_W;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sbox_f_sequencer.sv
// tb_sbox_f_sequencer: scoreboard bench for sbox_f_sequencer with directed vectors
module tb_sbox_f_sequencer;
`ifdef SBOX_SYNC_ROM_EN
  localparam int LAT = 9;
  localparam int PH  = 2;
`else
  localparam int LAT = 5;
  localparam int PH  = 1;
`endif
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] x_in = 0;
  logic busy, done;
  logic [31:0] f_out, sbox_data;
  logic [1:0] sbox_sel;
  logic [7:0] sbox_idx;
  bit ff = 0;
  int cyc = 0, pass = 0, total = 0, bcnt = 0;
  logic [31:0] fq[$];
  int cq[$];
  logic [9:0] lq[$];

  sbox_f_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .busy(busy), .done(done),
    .f_out(f_out), .sbox_sel(sbox_sel), .sbox_idx(sbox_idx), .sbox_data(sbox_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(logic [1:0] s, logic [7:0] i);
    return ff ? 32'hFFFFFFFF : {24'h0, i} << (8 * s);
  endfunction

`ifdef SBOX_SYNC_ROM_EN
  always @(posedge clk) sbox_data <= model(sbox_sel, sbox_idx);
`else
  always_comb sbox_data = model(sbox_sel, sbox_idx);
`endif

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  task automatic issue(logic [31:0] x, logic [31:0] exp);
    start = 1;
    x_in = x;
    fq.push_back(exp);
    cq.push_back(cyc + LAT);
    for (int i = 0; i < 4; i++) lq.push_back({2'(i), x[31-8*i -: 8]});
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && fq.size() != 0; i++) @(posedge clk);
    #1 chk("drain", fq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (busy) begin
      if (lq.size() == 0) chk("unexpected_lookup", 1, 0);
      else begin
        chk("sel", sbox_sel, lq[0][9:8]);
        chk("idx", sbox_idx, lq[0][7:0]);
      end
      bcnt++;
      if (bcnt % PH == 0 && lq.size() != 0) void'(lq.pop_front());
    end else bcnt = 0;
    if (done) begin
      if (fq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        chk("f_out", f_out, fq.pop_front());
        chk("done_cycle", cyc, cq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_f", f_out, 0);
    chk("rst_sel", sbox_sel, 0);
    chk("rst_idx", sbox_idx, 0);
    issue(32'h01020304, 32'h04030201);
    wait_done();
    repeat (3) @(posedge clk);
    #1 chk("hold_f", f_out, 32'h04030201);
    chk("hold_sel", sbox_sel, 3);
    chk("hold_idx", sbox_idx, 8'h04);
    chk("hold_busy", busy, 0);
    ff = 1;
    issue(32'hDEADBEEF, 32'h00000000);
    wait_done();
    ff = 0;
    issue(32'h01020304, 32'h04030201);
    repeat (LAT - 1) @(posedge clk);
    #1 issue(32'h0A0B0C0D, 32'h0D0C0B0A);
    wait_done();
    issue(32'h11223344, 32'h44332211);
    @(posedge clk);
    #1 start = 1;
    x_in = 32'hAABBCCDD;
    @(posedge clk);
    #1 x_in = 32'h55667788;
    @(posedge clk);
    #1 start = 0;
    wait_done();
    issue(32'hCAFEF00D, 32'h0DF0FECA);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    fq.delete();
    cq.delete();
    lq.delete();
    #1 rst = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_f", f_out, 0);
    chk("abort_sel", sbox_sel, 0);
    chk("abort_idx", sbox_idx, 0);
    repeat (LAT + 2) @(posedge clk);
    #1 issue(32'h01020304, 32'h04030201);
    wait_done();
    rst = 1;
    start = 1;
    x_in = 32'h12345678;
    @(posedge clk);
    #1 rst = 0;
    start = 0;
    chk("rst_start_busy", busy, 0);
    repeat (LAT + 2) @(posedge clk);
    #1 chk("lq_empty", lq.size(), 0);
    chk("f_after_rst", f_out, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
